// File: rtl/apu_pkg.sv
// Shared APU constants: register addresses, length-counter lookup table and
// the write-decode type used by the channel register front ends.
package apu_pkg;

  localparam logic [15:0] TRI_LINEAR_ADDR   = 16'h4008;
  localparam logic [15:0] TRI_TIMER_LO_ADDR = 16'h400A;
  localparam logic [15:0] TRI_TIMER_HI_ADDR = 16'h400B;
  localparam logic [15:0] APU_STATUS_ADDR   = 16'h4015;

  localparam int LENGTH_IDX_W = 5;
  localparam int LENGTH_W     = 8;
  localparam int LINEAR_W     = 7;

  // Length counter load values, indexed by the 5-bit field of the high timer write.
  localparam logic [LENGTH_W-1:0] LENGTH_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  typedef enum logic [2:0] {
    WR_NONE,
    WR_LINEAR,
    WR_TIMER_LO,
    WR_TIMER_HI,
    WR_STATUS
  } tri_write_e;

  function automatic logic [LENGTH_W-1:0] lengthLookup(input logic [LENGTH_IDX_W-1:0] idx);
    return LENGTH_TABLE[idx];
  endfunction

endpackage

// File: rtl/apu_length_counter.sv
// Frame-clocked APU length counter: table load, halt, channel enable and
// saturating decrement. Shared by the pulse, triangle and noise voices.
module apu_length_counter
  import apu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    lengthLoad,
  input  logic [LENGTH_IDX_W-1:0] lengthIndex,
  input  logic                    enableWrite,
  input  logic                    enableValue,
  input  logic                    halt,
  input  logic                    halfFrame,
  output logic [LENGTH_W-1:0]     count
);

  logic enable;

  // Priority: disable clears, then a table load, then the half-frame decrement.
  // A load in the same cycle as a half-frame pulse therefore suppresses the decrement.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      enable <= 1'b0;
      count  <= '0;
    end else begin
      if (enableWrite) begin
        enable <= enableValue;
      end

      if (enableWrite && !enableValue) begin
        count <= '0;
      end else if (!enable) begin
        count <= '0;
      end else if (lengthLoad) begin
        count <= lengthLookup(lengthIndex);
      end else if (halfFrame && !halt && count != '0) begin
        count <= count - LENGTH_W'(1);
      end
    end
  end

endmodule

// File: rtl/apu_triangle_regs.sv
// Triangle voice register front end: CPU write decode, channel registers,
// linear counter with reload flag, and the length counter instance.
module apu_triangle_regs
  import apu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [7:0]          data,
  input  logic                we,
  input  logic                quarter_frame,
  input  logic                half_frame,
  output logic [7:0]          inputReg1,
  output logic [7:0]          inputReg2,
  output logic [7:0]          inputReg3,
  output logic [LENGTH_W-1:0] length_count,
  output logic [LINEAR_W-1:0] linear_count,
  output logic                channel_active,
  output logic                status_tri
);

  tri_write_e writeSel;
  logic       timerHiWrite;
  logic       reloadFlag;

  always_comb begin
    writeSel = WR_NONE;
    if (we) begin
      if (addr == ADDR_W'(TRI_LINEAR_ADDR))        writeSel = WR_LINEAR;
      else if (addr == ADDR_W'(TRI_TIMER_LO_ADDR)) writeSel = WR_TIMER_LO;
      else if (addr == ADDR_W'(TRI_TIMER_HI_ADDR)) writeSel = WR_TIMER_HI;
      else if (addr == ADDR_W'(APU_STATUS_ADDR))   writeSel = WR_STATUS;
    end
  end

  assign timerHiWrite = (writeSel == WR_TIMER_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      inputReg1    <= '0;
      inputReg2    <= '0;
      inputReg3    <= '0;
      linear_count <= '0;
      reloadFlag   <= 1'b0;
    end else begin
      case (writeSel)
        WR_LINEAR:   inputReg1 <= data;
        WR_TIMER_LO: inputReg2 <= data;
        WR_TIMER_HI: inputReg3 <= data;
        default: ;
      endcase

      // inputReg1 is read before this edge's write lands, so a same-cycle
      // $4008 write only affects the next frame pulse.
      if (quarter_frame) begin
        if (reloadFlag || timerHiWrite) begin
          linear_count <= inputReg1[LINEAR_W-1:0];
        end else if (linear_count != '0) begin
          linear_count <= linear_count - LINEAR_W'(1);
        end
      end

      if (timerHiWrite) begin
        reloadFlag <= 1'b1;
      end else if (quarter_frame && !inputReg1[7]) begin
        reloadFlag <= 1'b0;
      end
    end
  end

  apu_length_counter u_length (
    .clk         (clk),
    .reset       (reset),
    .lengthLoad  (timerHiWrite),
    .lengthIndex (data[7:3]),
    .enableWrite (writeSel == WR_STATUS),
    .enableValue (data[2]),
    .halt        (inputReg1[7]),
    .halfFrame   (half_frame),
    .count       (length_count)
  );

  assign status_tri     = (length_count != '0);
  assign channel_active = status_tri && (linear_count != '0);

endmodule

// File: tb/tb_apu_triangle_regs.sv
// Directed bench for apu_triangle_regs: a behavioural register/counter model
// checked every cycle, plus literal expectations at key points.
module tb_apu_triangle_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        we;
  logic        quarter_frame;
  logic        half_frame;
  logic [7:0]  inputReg1, inputReg2, inputReg3, length_count;
  logic [6:0]  linear_count;
  logic        channel_active, status_tri;

  int passCount = 0;
  int totalCount = 0;

  apu_triangle_regs #(.ADDR_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .addr           (addr),
    .data           (data),
    .we             (we),
    .quarter_frame  (quarter_frame),
    .half_frame     (half_frame),
    .inputReg1      (inputReg1),
    .inputReg2      (inputReg2),
    .inputReg3      (inputReg3),
    .length_count   (length_count),
    .linear_count   (linear_count),
    .channel_active (channel_active),
    .status_tri     (status_tri)
  );

  always #5 clk = ~clk;

  int lenTable [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  // Model state, as plain integers.
  int  mReg1, mReg2, mReg3, mLen, mLin;
  bit  mFlag, mEn;
  bit  modelValid = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    totalCount++;
    if (actual == expected) passCount++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Next model state from the values present before the clock edge.
  task automatic modelUpdate(input bit rst, input int a, input int d, input bit w,
                             input bit qf, input bit hf);
    int  nLen, nLin;
    bit  nFlag, haltOld, wHi;
    if (rst) begin
      mReg1 = 0; mReg2 = 0; mReg3 = 0; mLen = 0; mLin = 0; mFlag = 0; mEn = 0;
      modelValid = 1'b1;
      return;
    end
    haltOld = (mReg1 >= 128);
    wHi = w && a == 'h400B;
    nLen = mLen;
    if (hf && !haltOld && mLen > 0) nLen = mLen - 1;
    if (wHi && mEn) nLen = lenTable[d / 8];
    if (w && a == 'h4015 && (d & 4) == 0) nLen = 0;
    nLin = mLin;
    if (qf) begin
      if (mFlag || wHi) nLin = mReg1 % 128;
      else if (mLin > 0) nLin = mLin - 1;
    end
    nFlag = mFlag;
    if (qf && !haltOld) nFlag = 0;
    if (wHi) nFlag = 1;
    if (w && a == 'h4008) mReg1 = d;
    if (w && a == 'h400A) mReg2 = d;
    if (wHi) mReg3 = d;
    if (w && a == 'h4015) mEn = (d & 4) != 0;
    mLen = nLen; mLin = nLin; mFlag = nFlag;
  endtask

  task automatic step(input bit rst, input int a, input int d, input bit w,
                      input bit qf, input bit hf);
    reset = rst; addr = 16'(a); data = 8'(d); we = w;
    quarter_frame = qf; half_frame = hf;
    @(posedge clk);
    modelUpdate(rst, a, d, w, qf, hf);
    @(negedge clk);
    reset = 1'b0; we = 1'b0; quarter_frame = 1'b0; half_frame = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    step(1'b0, a, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic frame(input bit qf, input bit hf);
    step(1'b0, 0, 0, 1'b0, qf, hf);
  endtask

  // Compare process: every negedge once the model has seen a reset.
  always @(negedge clk) begin
    if (modelValid) begin
      check("m_reg1", int'(inputReg1), mReg1);
      check("m_reg2", int'(inputReg2), mReg2);
      check("m_reg3", int'(inputReg3), mReg3);
      check("m_len", int'(length_count), mLen);
      check("m_lin", int'(linear_count), mLin);
      check("m_status", int'(status_tri), int'(mLen != 0));
      check("m_active", int'(channel_active), int'(mLen != 0 && mLin != 0));
    end
  end

  initial begin
    reset = 1'b1; addr = '0; data = '0; we = 1'b0;
    quarter_frame = 1'b0; half_frame = 1'b0;
    @(negedge clk);
    step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    check("rst_len", int'(length_count), 0);
    check("rst_lin", int'(linear_count), 0);
    check("rst_reg1", int'(inputReg1), 0);
    check("rst_active", int'(channel_active), 0);

    // Halted length counter ignores half frames.
    wr('h4015, 'h04); wr('h4008, 'h81); wr('h400B, 'h08);
    check("load_reg3", int'(inputReg3), 'h08);
    check("load_len254", int'(length_count), 254);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b1);
    check("halt_len", int'(length_count), 254);

    // Linear reload then countdown.
    wr('h4008, 'h05); wr('h400B, 'h00);
    check("len10", int'(length_count), 10);
    frame(1'b1, 1'b0);
    check("lin_reload5", int'(linear_count), 5);
    check("active_on", int'(channel_active), 1);
    for (int i = 0; i < 4; i++) frame(1'b1, 1'b0);
    check("lin1", int'(linear_count), 1);
    frame(1'b1, 1'b0);
    check("lin0", int'(linear_count), 0);
    check("active_off", int'(channel_active), 0);
    frame(1'b1, 1'b0);
    check("lin_sat", int'(linear_count), 0);

    // Enable gating.
    wr('h4015, 'h00);
    check("dis_len", int'(length_count), 0);
    wr('h400B, 'hF8);
    check("dis_load", int'(length_count), 0);
    wr('h4015, 'h04); wr('h400B, 'hF8);
    check("len30", int'(length_count), 30);
    check("status_on", int'(status_tri), 1);
    wr('h4015, 'h00);
    check("dis_clear", int'(length_count), 0);

    // Load beats a same-cycle half frame; then saturating decrement.
    wr('h4015, 'h04);
    step(1'b0, 'h400B, 'h18, 1'b1, 1'b0, 1'b1);
    check("load_vs_hf", int'(length_count), 2);
    frame(1'b0, 1'b1);
    check("len_dec1", int'(length_count), 1);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b1);
    check("len_sat0", int'(length_count), 0);

    // $400B with quarter frame: reload now, flag survives into the next pulse.
    step(1'b0, 'h400B, 'h18, 1'b1, 1'b1, 1'b0);
    check("qf_load5", int'(linear_count), 5);
    frame(1'b1, 1'b0);
    check("qf_flag_kept", int'(linear_count), 5);
    frame(1'b1, 1'b0);
    check("qf_dec4", int'(linear_count), 4);

    // $4008 with quarter frame: old reload value (5) used, flag already clear.
    wr('h400B, 'h18);
    step(1'b0, 'h4008, 'h83, 1'b1, 1'b1, 1'b0);
    check("old_reg1_used", int'(linear_count), 5);
    check("reg1_83", int'(inputReg1), 'h83);

    // Control flag keeps reload asserted.
    wr('h400B, 'h20);
    for (int i = 0; i < 10; i++) frame(1'b1, 1'b0);
    check("ctrl_hold3", int'(linear_count), 3);
    check("len40", int'(length_count), 40);
    frame(1'b1, 1'b1);
    check("both_len", int'(length_count), 40);

    // Ignored addresses.
    wr('h400A, 'h5A);
    wr('h4009, 'hFF); wr('h4010, 'hFF);
    check("ign_reg1", int'(inputReg1), 'h83);
    check("ign_reg2", int'(inputReg2), 'h5A);
    check("ign_reg3", int'(inputReg3), 'h20);

    // Reset mid-operation drops pending frame pulses.
    step(1'b1, 'h400B, 'h08, 1'b1, 1'b1, 1'b1);
    check("rst2_len", int'(length_count), 0);
    check("rst2_lin", int'(linear_count), 0);
    check("rst2_reg1", int'(inputReg1), 0);
    check("rst2_reg3", int'(inputReg3), 0);
    check("rst2_status", int'(status_tri), 0);
    wr('h400B, 'h08);
    check("rst2_enable_cleared", int'(length_count), 0);

    frame(1'b0, 1'b0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
